// File: rtl/audio_dac_ctrl.sv
// audio_dac_ctrl
//   Sample-rate scheduler for the stereo sigma-delta DAC pair. Pulls packed
//   stereo PCM words from an upstream FIFO (valid/accept) once per programmable
//   sample period and holds each sample on left_o/right_o for exactly one period.
//   Counts underruns and sequences IDLE -> PRIME -> RUN so the DACs never see a
//   torn or stale sample.
//
//   Build option: define AUDIO_DAC_CTRL_HOLD_EN to hold the last latched sample
//   on underrun; otherwise the outputs drop to midscale (0) until the next
//   successful transfer.
//
// Ports
//   clk_i            system clock
//   rst_i            asynchronous active-low reset
//   enable_i         run request; low returns to IDLE on the next edge
//   mute_i           latch zeros instead of the offered sample (still consumed)
//   clk_div_i        sample period minus one, sampled on reload only
//   stats_clr_i      synchronous clear of underrun_count_o (wins over increment)
//   inport_valid_i   upstream sample word available
//   inport_data_i    {left, right} packed sample word
//   inport_accept_o  sample taken on the edge where valid && accept
//   left_o/right_o   registered DAC samples
//   sample_tick_o    one-cycle pulse, high in the cycle a RUN boundary takes effect
//   underrun_o       one-cycle pulse, high in the cycle after a boundary missed data
//   underrun_count_o saturating underrun counter
//   busy_o           high in PRIME or RUN

module audio_dac_ctrl #(
  parameter int NBITS = 16,
  parameter int DIV_W = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               enable_i,
  input  logic               mute_i,
  input  logic [DIV_W-1:0]   clk_div_i,
  input  logic               stats_clr_i,
  input  logic               inport_valid_i,
  input  logic [2*NBITS-1:0] inport_data_i,
  output logic               inport_accept_o,
  output logic [NBITS-1:0]   left_o,
  output logic [NBITS-1:0]   right_o,
  output logic               sample_tick_o,
  output logic               underrun_o,
  output logic [15:0]        underrun_count_o,
  output logic               busy_o
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PRIME = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;

  localparam logic [NBITS-1:0] ZERO_SMP = {NBITS{1'b0}};
  localparam logic [DIV_W-1:0] ZERO_CNT = {DIV_W{1'b0}};
  localparam logic [DIV_W-1:0] ONE_CNT  = {{(DIV_W-1){1'b0}}, 1'b1};

  logic [1:0]       state_r, state_nxt_s;
  logic [DIV_W-1:0] count_r, count_nxt_s;
  logic [NBITS-1:0] left_r, left_nxt_s;
  logic [NBITS-1:0] right_r, right_nxt_s;
  logic             tick_r, tick_nxt_s;
  logic             underrun_r, underrun_nxt_s;
  logic [15:0]      ucount_r, ucount_nxt_s;
  logic             busy_r, busy_nxt_s;
  logic             boundary_s;
  logic [NBITS-1:0] smp_left_s, smp_right_s;

  // Boundary = last cycle of a RUN period; the handshake window opens only here
  // (and throughout PRIME). Gated by enable_i so a cycle that is about to fall
  // back to IDLE never completes a transfer.
  assign boundary_s      = (state_r == ST_RUN) && (count_r == ZERO_CNT);
  assign inport_accept_o = enable_i && ((state_r == ST_PRIME) || boundary_s);

  // Mute is applied at latch time, so it only takes effect on a transfer.
  assign smp_left_s  = mute_i ? ZERO_SMP : inport_data_i[2*NBITS-1:NBITS];
  assign smp_right_s = mute_i ? ZERO_SMP : inport_data_i[NBITS-1:0];

  // Next-state, divider, sample and pulse computation.
  always_comb begin
    state_nxt_s    = state_r;
    count_nxt_s    = count_r;
    left_nxt_s     = left_r;
    right_nxt_s    = right_r;
    tick_nxt_s     = 1'b0;
    underrun_nxt_s = 1'b0;
    if (!enable_i) begin
      state_nxt_s = ST_IDLE;
      count_nxt_s = ZERO_CNT;
      left_nxt_s  = ZERO_SMP;
      right_nxt_s = ZERO_SMP;
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_nxt_s = ST_PRIME;
          count_nxt_s = ZERO_CNT;
          left_nxt_s  = ZERO_SMP;
          right_nxt_s = ZERO_SMP;
        end
        ST_PRIME: begin
          // Waiting for the first word is not an underrun.
          if (inport_valid_i) begin
            state_nxt_s = ST_RUN;
            count_nxt_s = clk_div_i;
            left_nxt_s  = smp_left_s;
            right_nxt_s = smp_right_s;
          end else begin
            state_nxt_s = ST_PRIME;
          end
        end
        ST_RUN: begin
          if (count_r == ZERO_CNT) begin
            count_nxt_s = clk_div_i;
            tick_nxt_s  = 1'b1;
            if (inport_valid_i) begin
              left_nxt_s  = smp_left_s;
              right_nxt_s = smp_right_s;
            end else begin
              underrun_nxt_s = 1'b1;
`ifdef AUDIO_DAC_CTRL_HOLD_EN
              left_nxt_s  = left_r;
              right_nxt_s = right_r;
`else
              left_nxt_s  = ZERO_SMP;
              right_nxt_s = ZERO_SMP;
`endif
            end
          end else begin
            count_nxt_s = count_r - ONE_CNT;
          end
        end
        default: begin
          state_nxt_s = ST_IDLE;
          count_nxt_s = ZERO_CNT;
          left_nxt_s  = ZERO_SMP;
          right_nxt_s = ZERO_SMP;
        end
      endcase
    end
  end

  // Underrun counter: clear has priority, increment saturates at all-ones.
  always_comb begin
    ucount_nxt_s = ucount_r;
    if (stats_clr_i) begin
      ucount_nxt_s = 16'h0000;
    end else if (underrun_nxt_s && (ucount_r != 16'hFFFF)) begin
      ucount_nxt_s = ucount_r + 16'h0001;
    end else begin
      ucount_nxt_s = ucount_r;
    end
    busy_nxt_s = (state_nxt_s != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_r    <= ST_IDLE;
      count_r    <= ZERO_CNT;
      left_r     <= ZERO_SMP;
      right_r    <= ZERO_SMP;
      tick_r     <= 1'b0;
      underrun_r <= 1'b0;
      ucount_r   <= 16'h0000;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      count_r    <= count_nxt_s;
      left_r     <= left_nxt_s;
      right_r    <= right_nxt_s;
      tick_r     <= tick_nxt_s;
      underrun_r <= underrun_nxt_s;
      ucount_r   <= ucount_nxt_s;
      busy_r     <= busy_nxt_s;
    end
  end

  assign left_o           = left_r;
  assign right_o          = right_r;
  assign sample_tick_o    = tick_r;
  assign underrun_o       = underrun_r;
  assign underrun_count_o = ucount_r;
  assign busy_o           = busy_r;

endmodule

// File: tb/tb_audio_dac_ctrl.sv
// tb_audio_dac_ctrl
//   Directed bench for audio_dac_ctrl. A cycle-level reference model tracks the
//   absolute cycle number of the next sample boundary (rather than a divider
//   count) and predicts every output; a compare process checks it each cycle.
//   Directed steps add hand-computed literal checks. Honours
//   AUDIO_DAC_CTRL_HOLD_EN the same way as the design.

module tb_audio_dac_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        enable_i;
  logic        mute_i;
  logic [15:0] clk_div_i;
  logic        stats_clr_i;
  logic        inport_valid_i;
  logic [31:0] inport_data_i;
  logic        inport_accept_o;
  logic [15:0] left_o;
  logic [15:0] right_o;
  logic        sample_tick_o;
  logic        underrun_o;
  logic [15:0] underrun_count_o;
  logic        busy_o;

  audio_dac_ctrl #(.NBITS(16), .DIV_W(16)) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .enable_i         (enable_i),
    .mute_i           (mute_i),
    .clk_div_i        (clk_div_i),
    .stats_clr_i      (stats_clr_i),
    .inport_valid_i   (inport_valid_i),
    .inport_data_i    (inport_data_i),
    .inport_accept_o  (inport_accept_o),
    .left_o           (left_o),
    .right_o          (right_o),
    .sample_tick_o    (sample_tick_o),
    .underrun_o       (underrun_o),
    .underrun_count_o (underrun_count_o),
    .busy_o           (busy_o)
  );

  always #5 clk_i = ~clk_i;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int acc_seen  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: actual %0h required %0h at %0t", nm, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  longint cyc      = 0;
  longint m_next_b = 0;   // absolute cycle index of the next RUN boundary
  bit     m_on     = 1'b0; // PRIME or RUN
  bit     m_run    = 1'b0; // first sample taken
  logic [15:0] e_left = 16'h0, e_right = 16'h0;
  bit     e_tick = 1'b0, e_under = 1'b0, e_busy = 1'b0, e_acc;
  int     e_cnt = 0;

  always @(negedge clk_i) begin
    cyc++;
    if (!rst_i) begin
      m_on = 1'b0; m_run = 1'b0; e_left = 16'h0; e_right = 16'h0;
      e_tick = 1'b0; e_under = 1'b0; e_busy = 1'b0; e_cnt = 0;
    end
    e_acc = rst_i && enable_i && m_on && (!m_run || cyc == m_next_b);
    chk("accept", inport_accept_o, e_acc);
    chk("left", left_o, e_left);
    chk("right", right_o, e_right);
    chk("tick", sample_tick_o, e_tick);
    chk("underrun", underrun_o, e_under);
    chk("ucount", underrun_count_o, e_cnt);
    chk("busy", busy_o, e_busy);
    if (inport_valid_i && inport_accept_o) acc_seen++;
    if (rst_i) begin
      e_tick = 1'b0; e_under = 1'b0;
      if (!enable_i) begin
        m_on = 1'b0; m_run = 1'b0; e_left = 16'h0; e_right = 16'h0;
      end else if (!m_on) begin
        m_on = 1'b1;
      end else if (!m_run) begin
        if (inport_valid_i) begin
          e_left  = mute_i ? 16'h0 : inport_data_i[31:16];
          e_right = mute_i ? 16'h0 : inport_data_i[15:0];
          m_run = 1'b1;
          m_next_b = cyc + clk_div_i + 1;
        end
      end else if (cyc == m_next_b) begin
        e_tick = 1'b1;
        m_next_b = cyc + clk_div_i + 1;
        if (inport_valid_i) begin
          e_left  = mute_i ? 16'h0 : inport_data_i[31:16];
          e_right = mute_i ? 16'h0 : inport_data_i[15:0];
        end else begin
          e_under = 1'b1;
`ifndef AUDIO_DAC_CTRL_HOLD_EN
          e_left = 16'h0; e_right = 16'h0;
`endif
        end
      end
      if (stats_clr_i) e_cnt = 0;
      else if (e_under && e_cnt < 65535) e_cnt++;
      e_busy = m_on;
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic wait_accept();
    int n = 0;
    while (inport_accept_o !== 1'b1 && n < 40) begin
      step(1);
      n++;
    end
    chk("accept_reached", inport_accept_o, 1'b1);
  endtask

  int a0;

  initial begin
    rst_i = 1'b0; enable_i = 1'b0; mute_i = 1'b0; clk_div_i = 16'd0;
    stats_clr_i = 1'b0; inport_valid_i = 1'b0; inport_data_i = 32'h0;
    step(3);
    rst_i = 1'b1;
    step(2);

    // Basic streaming, period 4.
    clk_div_i = 16'd3; inport_valid_i = 1'b1; inport_data_i = 32'h1234_ABCD;
    enable_i = 1'b1;
    step(1);
    chk("prime_accept", inport_accept_o, 1'b1);
    step(1);
    chk("first_left", left_o, 16'h1234);
    chk("first_right", right_o, 16'hABCD);
    chk("model_left_pin", e_left, 16'h1234);
    a0 = acc_seen;
    step(20);
    chk("accepts_per_20_div3", acc_seen - a0, 5);
    chk("no_underrun", underrun_count_o, 16'h0);

    // Drop valid at one boundary.
    wait_accept();
    inport_valid_i = 1'b0;
    step(1);
    inport_valid_i = 1'b1;
    chk("underrun_pulse", underrun_o, 1'b1);
    chk("underrun_count_1", underrun_count_o, 16'd1);
`ifdef AUDIO_DAC_CTRL_HOLD_EN
    chk("underrun_hold_left", left_o, 16'h1234);
`else
    chk("underrun_zero_left", left_o, 16'h0);
`endif
    step(1);
    chk("underrun_single", underrun_o, 1'b0);

    // Mute, and mute toggled mid-period.
    mute_i = 1'b1; inport_data_i = 32'h7FFF_8000;
    wait_accept();
    step(1);
    chk("mute_left", left_o, 16'h0);
    chk("mute_right", right_o, 16'h0);
    step(1);
    mute_i = 1'b0;
    step(1);
    chk("mute_mid_hold", left_o, 16'h0);
    wait_accept();
    step(1);
    chk("unmute_left", left_o, 16'h7FFF);
    chk("unmute_right", right_o, 16'h8000);
    mute_i = 1'b1;
    step(1);
    chk("mute_mid_keep", left_o, 16'h7FFF);
    mute_i = 1'b0;

    // Divider 0, then 9 changed mid-period.
    clk_div_i = 16'd0;
    wait_accept();
    step(1);
    a0 = acc_seen;
    step(8);
    chk("accepts_div0", acc_seen - a0, 8);
    clk_div_i = 16'd3;
    step(2);
    clk_div_i = 16'd9;
    step(14);
    a0 = acc_seen;
    step(30);
    chk("accepts_per_30_div9", acc_seen - a0, 3);

    // Saturation and clear-vs-underrun.
    clk_div_i = 16'd0; inport_valid_i = 1'b0;
    step(12);
    stats_clr_i = 1'b1;
    step(1);
    stats_clr_i = 1'b0;
    chk("clr_count", underrun_count_o, 16'h0);
    step(65540);
    chk("saturate", underrun_count_o, 16'hFFFF);
    stats_clr_i = 1'b1;
    step(1);
    stats_clr_i = 1'b0;
    chk("clr_beats_underrun", underrun_count_o, 16'h0);
    chk("clr_cycle_underrun", underrun_o, 1'b1);
    step(1);
    chk("count_after_clr", underrun_count_o, 16'd1);

    // Enable dropped mid-period.
    inport_valid_i = 1'b1; inport_data_i = 32'h1234_ABCD; clk_div_i = 16'd3;
    step(12);
    step(1);
    enable_i = 1'b0;
    #1;
    chk("disable_no_accept", inport_accept_o, 1'b0);
    step(1);
    chk("disable_busy", busy_o, 1'b0);
    chk("disable_left", left_o, 16'h0);
    chk("disable_right", right_o, 16'h0);
    step(3);

    // Async reset in RUN.
    enable_i = 1'b1;
    step(2);
    step(2);
    chk("run_before_reset", left_o, 16'h1234);
    rst_i = 1'b0;
    #1;
    chk("reset_left", left_o, 16'h0);
    chk("reset_right", right_o, 16'h0);
    chk("reset_busy", busy_o, 1'b0);
    chk("reset_count", underrun_count_o, 16'h0);
    chk("reset_accept", inport_accept_o, 1'b0);
    step(2);
    rst_i = 1'b1;
    step(4);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
